// File: rtl/core_pkg.sv
// Shared types and funct3 codes for the core's memory path.
// Holds the bridge FSM encoding, the APB request payload and the lane helpers.
package core_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } bridge_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [XLEN-1:0]   paddr;
        logic              pwrite;
        logic [XLEN-1:0]   pwdata;
        logic [STRB_W-1:0] pstrb;
    } apb_req_t;

    // Unsupported size codes and misaligned halves/words never reach the bus.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lo);
        logic fault;
        case (f3)
            F3_LB, F3_LBU: fault = 1'b0;
            F3_LH, F3_LHU: fault = lo[0];
            F3_LW:         fault = |lo;
            default:       fault = 1'b1;
        endcase
        return fault;
    endfunction

    function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] f3, input logic [1:0] lo);
        logic [STRB_W-1:0] strb;
        case (f3)
            F3_SB, F3_LBU: strb = 4'b0001 << lo;
            F3_SH, F3_LHU: strb = 4'b0011 << {lo[1], 1'b0};
            F3_SW:         strb = 4'b1111;
            default:       strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] wd);
        logic [XLEN-1:0] data;
        case (f3)
            F3_SB, F3_LBU: data = {4{wd[7:0]}};
            F3_SH, F3_LHU: data = {2{wd[15:0]}};
            default:       data = wd;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Moves the addressed load lane down to bit 0 and applies sign/zero extension.
module mem_lane_align
    import core_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data_c
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        data_c  = '0;
        case (funct3)
            F3_LB:   data_c = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data_c = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_c = shifted;
            F3_LBU:  data_c = {24'h0, shifted[7:0]};
            F3_LHU:  data_c = {16'h0, shifted[15:0]};
            default: data_c = '0;
        endcase
    end

endmodule

// File: rtl/apb_mem_bridge.sv
// Core load/store port to APB master bridge (IDLE/SETUP/ACCESS/DONE).
// Define APB_TIMEOUT_EN to bound ACCESS by TIMEOUT_CYCLES wait states.
module apb_mem_bridge
    import core_pkg::*;
`ifdef APB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read_en,
    input  logic              mem_write_en,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    input  logic [2:0]        mem_funct3,
    output logic              mem_ready,
    output logic              mem_err,
    output logic [XLEN-1:0]   mem_rdata,
    output logic [XLEN-1:0]   paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [XLEN-1:0]   pwdata,
    output logic [STRB_W-1:0] pstrb,
    input  logic [XLEN-1:0]   prdata,
    input  logic              pready,
    input  logic              pslverr
);

    bridge_state_e   state_q, state_d;
    apb_req_t        apb_q, apb_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            psel_q, psel_d;
    logic            penable_q, penable_d;
    logic            mem_ready_q, mem_ready_d;
    logic            mem_err_q, mem_err_d;
    logic [XLEN-1:0] mem_rdata_q, mem_rdata_d;
    logic [XLEN-1:0] load_data_c;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    mem_lane_align u_align (
        .rdata   (prdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data_c  (load_data_c)
    );

    always_comb begin
        state_d     = state_q;
        apb_d       = apb_q;
        addr_lo_d   = addr_lo_q;
        funct3_d    = funct3_q;
        mem_err_d   = 1'b0;
        mem_rdata_d = mem_rdata_q;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_read_en || mem_write_en) begin
                    apb_d.paddr  = {mem_addr[31:2], 2'b00};
                    apb_d.pwrite = mem_write_en;
                    apb_d.pwdata = lane_wdata(mem_funct3, mem_wdata);
                    apb_d.pstrb  = mem_write_en ? lane_strb(mem_funct3, mem_addr[1:0]) : '0;
                    addr_lo_d    = mem_addr[1:0];
                    funct3_d     = mem_funct3;
                    if (access_fault(mem_funct3, mem_addr[1:0])) begin
                        state_d     = ST_DONE;
                        mem_err_d   = 1'b1;
                        mem_rdata_d = '0;
                    end else begin
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    state_d = ST_DONE;
                    if (pslverr) begin
                        mem_err_d   = 1'b1;
                        mem_rdata_d = '0;
                    end else begin
                        mem_rdata_d = apb_q.pwrite ? '0 : load_data_c;
                    end
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_DONE;
                    mem_err_d   = 1'b1;
                    mem_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Bus strobes follow the state being entered so they stay registered.
        psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d   = (state_d == ST_ACCESS);
        mem_ready_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            apb_q       <= '0;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            apb_q       <= apb_d;
            addr_lo_q   <= addr_lo_d;
            funct3_q    <= funct3_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            mem_ready_q <= mem_ready_d;
            mem_err_q   <= mem_err_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign paddr     = apb_q.paddr;
    assign pwrite    = apb_q.pwrite;
    assign pwdata    = apb_q.pwdata;
    assign pstrb     = apb_q.pstrb;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign mem_ready = mem_ready_q;
    assign mem_err   = mem_err_q;
    assign mem_rdata = mem_rdata_q;

endmodule
